// File: rtl/demux_dispatcher.sv
// Round-robin feeder for a 1-to-4 demux: accepts one word at a time, drives it
// on the chosen channel for a programmable number of cycles, and counts words.
module demux_dispatcher #(
    parameter int DW     = 3,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    input  logic [3:0]           ch_en,
    input  logic [HOLD_W-1:0]    hold_cycles,
    input  logic                 clr_cnt,
    output logic [DW-1:0]        dmx_in,
    output logic [1:0]           dmx_sel,
    output logic                 dmx_strobe,
    output logic                 busy,
    output logic [4*CNT_W-1:0]   cnt
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready is high only when idle with at least one channel enabled;
    // while it is low, in_valid and in_data are ignored (no buffering).

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]        state_q,  state_d;
    logic [1:0]        ptr_q,    ptr_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic [DW-1:0]     data_q,   data_d;
    logic [1:0]        sel_q,    sel_d;
    logic              strobe_q, strobe_d;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];

    logic              accept;
    logic              done;
    logic [1:0]        pick_ch;
    logic [1:0]        cand;
    logic [HOLD_W-1:0] hold_load;

    assign in_ready  = (state_q == ST_IDLE) && (ch_en != 4'b0000);
    assign accept    = in_valid && in_ready;
    assign hold_load = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
    assign done      = (state_q == ST_DRIVE) && (hold_q <= HOLD_W'(1));

    // Search ptr+1, ptr+2, ptr+3, ptr; descending loop so the nearest wins.
    always_comb begin
        pick_ch = ptr_q;
        cand    = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr_q + 2'(k);
            if (ch_en[cand]) begin
                pick_ch = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        data_d   = data_q;
        sel_d    = sel_q;
        strobe_d = strobe_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_DRIVE;
                    hold_d   = hold_load;
                    data_d   = in_data;
                    sel_d    = pick_ch;
                    strobe_d = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (done) begin
                    state_d  = ST_IDLE;
                    ptr_d    = sel_q;
                    hold_d   = '0;
                    data_d   = '0;
                    strobe_d = 1'b0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                hold_d   = '0;
                data_d   = '0;
                strobe_d = 1'b0;
            end
        endcase
    end

    // Clear takes priority over a completion increment on the same edge.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_cnt) begin
                cnt_d[i] = '0;
            end else if (done && (sel_q == 2'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd3;
            hold_q   <= '0;
            data_q   <= '0;
            sel_q    <= '0;
            strobe_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            strobe_q <= strobe_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt[CNT_W*i +: CNT_W] = cnt_q[i];
        end
    end

    assign dmx_in     = data_q;
    assign dmx_sel    = sel_q;
    assign dmx_strobe = strobe_q;
    assign busy       = (state_q == ST_DRIVE);

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed + randomized bench for demux_dispatcher against a transaction-level
// model: round-robin pick, N-cycle strobe window, saturating per-channel counts.
module tb_demux_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_data;
    logic        in_ready;
    logic [3:0]  ch_en;
    logic [3:0]  hold_cycles;
    logic        clr_cnt;
    logic [2:0]  dmx_in;
    logic [1:0]  dmx_sel;
    logic        dmx_strobe;
    logic        busy;
    logic [31:0] cnt;

    int checks = 0;
    int errors = 0;
    int m_ptr;
    int m_cnt [4];

    demux_dispatcher dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .ch_en       (ch_en),
        .hold_cycles (hold_cycles),
        .clr_cnt     (clr_cnt),
        .dmx_in      (dmx_in),
        .dmx_sel     (dmx_sel),
        .dmx_strobe  (dmx_strobe),
        .busy        (busy),
        .cnt         (cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] en);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (en[c]) return c;
        end
        return 0;
    endfunction

    task automatic check_counts(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_cnt%0d", tag, i), 32'(cnt[8*i +: 8]), 32'(m_cnt[i]));
        end
    endtask

    task automatic model_reset();
        m_ptr = 3;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    // Call just after a negedge; returns just after the idle negedge that follows the word.
    task automatic send_word(input logic [2:0] data, input logic [3:0] en, input int hold, input bit clr);
        int n;
        int ch;
        n  = (hold == 0) ? 1 : hold;
        ch = pick(en);
        ch_en       = en;
        hold_cycles = 4'(hold);
        in_data     = data;
        in_valid    = 1'b1;
        #1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("strobe_on", 32'(dmx_strobe), 32'd1);
            check("dmx_in_word", 32'(dmx_in), 32'(data));
            check("dmx_sel_word", 32'(dmx_sel), 32'(ch));
            check("busy_on", 32'(busy), 32'd1);
            check("in_ready_drive", 32'(in_ready), 32'd0);
            // Activity during DRIVE must not disturb the word in flight.
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 3'($urandom_range(0, 7));
            ch_en    = 4'($urandom_range(0, 15));
            if (clr && i == n - 1) clr_cnt = 1'b1;
        end
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        in_valid = 1'b0;
        m_ptr = ch;
        if (clr) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (m_cnt[ch] < 255) begin
            m_cnt[ch]++;
        end
        @(negedge clk);
        ch_en = en;
        check("strobe_off", 32'(dmx_strobe), 32'd0);
        check("dmx_in_idle", 32'(dmx_in), 32'd0);
        check("dmx_sel_keep", 32'(dmx_sel), 32'(ch));
        check("busy_off", 32'(busy), 32'd0);
        check_counts("after_word");
    endtask

    initial begin
        logic [2:0] words [4];
        int ch;
        words = '{3'd5, 3'd6, 3'd7, 3'd1};
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ch_en = 4'b1111;
        hold_cycles = 4'd1; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_strobe", 32'(dmx_strobe), 32'd0);
        check("rst_dmx_in", 32'(dmx_in), 32'd0);
        check("rst_dmx_sel", 32'(dmx_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", cnt, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // 1: all channels, hold 1, four back-to-back words rotate a,b,c,d
        for (int i = 0; i < 4; i++) send_word(words[i], 4'b1111, 1, 1'b0);
        check("t1_cnt_all_one", cnt, 32'h01010101);

        // 2: channels b and d, hold 3
        send_word(3'd2, 4'b1010, 3, 1'b0);
        send_word(3'd3, 4'b1010, 3, 1'b0);
        send_word(3'd4, 4'b1010, 3, 1'b0);
        check("t2_cnt_b", 32'(cnt[15:8]), 32'd3);
        check("t2_cnt_d", 32'(cnt[31:24]), 32'd2);

        // 3: no enabled channel blocks acceptance
        ch_en = 4'b0000;
        in_valid = 1'b1;
        in_data = 3'd6;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_in_ready", 32'(in_ready), 32'd0);
            check("t3_strobe", 32'(dmx_strobe), 32'd0);
        end
        check_counts("t3");
        send_word(3'd6, 4'b0100, 1, 1'b0);
        check("t3_last_sel", 32'(dmx_sel), 32'd2);

        // 4: hold 0 acts as 1; counter saturates
        for (int i = 0; i < 300; i++) send_word(3'd7, 4'b0001, 0, 1'b0);
        check("t4_sat", 32'(cnt[7:0]), 32'd255);

        // 5: reset on second DRIVE cycle discards the word
        ch = pick(4'b1111);
        ch_en = 4'b1111; hold_cycles = 4'd4; in_data = 3'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("t5_strobe_c1", 32'(dmx_strobe), 32'd1);
        check("t5_sel_c1", 32'(dmx_sel), 32'(ch));
        @(negedge clk);
        check("t5_strobe_c2", 32'(dmx_strobe), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("t5_strobe_rst", 32'(dmx_strobe), 32'd0);
        check("t5_dmx_in_rst", 32'(dmx_in), 32'd0);
        check("t5_busy_rst", 32'(busy), 32'd0);
        check_counts("t5");
        send_word(3'd5, 4'b1111, 1, 1'b0);
        check("t5_next_ch0", 32'(dmx_sel), 32'd0);

        // 6: clear coinciding with a completion wins
        for (int i = 0; i < 5; i++) send_word(3'(i), 4'b0100, 1, 1'b0);
        check("t6_cnt_c5", 32'(cnt[23:16]), 32'd5);
        send_word(3'd1, 4'b0100, 2, 1'b1);
        check("t6_all_zero", cnt, 32'd0);

        // Randomized traffic with idle gaps and occasional clears
        for (int w = 0; w < 60; w++) begin
            logic [3:0] en;
            int gap;
            en = 4'($urandom_range(1, 15));
            send_word(3'($urandom_range(0, 7)), en, $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("gap_strobe", 32'(dmx_strobe), 32'd0);
                check("gap_busy", 32'(busy), 32'd0);
            end
        end
        check_counts("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
